// File: rtl/epcs_read_sequencer.sv
// epcs_read_sequencer: issues a serial-flash READ through the EPCS SPI core register port and streams the data bytes out
module epcs_read_sequencer #(
  parameter logic [7:0] CMD_READ = 8'h03,
  parameter logic [7:0] DUMMY_TX = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] start_addr,
  input  logic [15:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  spi_address,
  output logic        spi_chipselect,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_writedata,
  input  logic [15:0] spi_readdata,
  input  logic        spi_readyfordata,
  input  logic        spi_dataavailable
);
  typedef enum logic [2:0] {IDLE, SSO_ON, TX_WAIT, RX_WAIT, OUT_HOLD, SSO_OFF, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] ph, ph_nx;
  logic [23:0] addr;
  logic [15:0] rem;
  logic [2:0] hdr;
  logic [7:0] tx_byte;
  logic strobe;
  logic unused;
  assign unused = ^spi_readdata[15:8];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ph <= 2'd0;
    end else begin
      state <= state_nx;
      ph <= ph_nx;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= 24'd0;
      rem <= 16'd0;
      hdr <= 3'd0;
      out_data <= 8'd0;
      done <= 1'b0;
    end else begin
      done <= state == DONE;
      if (state == IDLE && start) begin
        addr <= start_addr;
        rem <= byte_count;
        hdr <= 3'd0;
      end
      if (state == RX_WAIT && ph == 2'd2) begin
        if (hdr != 3'd4) hdr <= hdr + 3'd1;
        else out_data <= spi_readdata[7:0];
      end
      if (state == OUT_HOLD && out_ready) rem <= rem - 16'd1;
    end
  end
  // ph: 0 = no access, 1/2 = the two strobe cycles; a wait state always returns to 0 before the next access
  always_comb begin
    state_nx = state;
    ph_nx = (ph == 2'd1) ? 2'd2 : 2'd0;
    case (state)
      IDLE: if (start) begin
        state_nx = (byte_count == 16'd0) ? DONE : SSO_ON;
        ph_nx = (byte_count == 16'd0) ? 2'd0 : 2'd1;
      end
      SSO_ON: if (ph == 2'd2) state_nx = TX_WAIT;
      TX_WAIT: begin
        if (ph == 2'd0 && spi_readyfordata) ph_nx = 2'd1;
        if (ph == 2'd2) state_nx = RX_WAIT;
      end
      RX_WAIT: begin
        if (ph == 2'd0 && spi_dataavailable) ph_nx = 2'd1;
        if (ph == 2'd2) state_nx = (hdr == 3'd4) ? OUT_HOLD : TX_WAIT;
      end
      OUT_HOLD: if (out_ready) begin
        state_nx = (rem == 16'd1) ? SSO_OFF : TX_WAIT;
        ph_nx = (rem == 16'd1 || spi_readyfordata) ? 2'd1 : 2'd0;
      end
      SSO_OFF: if (ph == 2'd2) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    strobe = ph != 2'd0;
    busy = state != IDLE;
    out_valid = state == OUT_HOLD;
    spi_chipselect = strobe;
    spi_read_n = !(strobe && state == RX_WAIT);
    spi_write_n = !(strobe && state != RX_WAIT);
    spi_address = (state == SSO_ON || state == SSO_OFF) ? 3'd3 : (state == TX_WAIT) ? 3'd1 : 3'd0;
    tx_byte = (hdr == 3'd0) ? CMD_READ : (hdr == 3'd1) ? addr[23:16] :
              (hdr == 3'd2) ? addr[15:8] : (hdr == 3'd3) ? addr[7:0] : DUMMY_TX;
    spi_writedata = (state == SSO_ON) ? 16'h0400 : (state == TX_WAIT) ? {8'h00, tx_byte} : 16'h0000;
  end
endmodule
